// File: rtl/serial_to_parallel_stream.sv
// serial_to_parallel_stream
//   Packs IN_W-bit input beats into OUT_W-bit words. Both sides use valid/ready.
//   A word closes on its BEATS-th beat, or early on any beat flagged in_last.
//   The closed word moves into an output register that holds it until consumed.
//   Optional feature macro: S2P_PARITY_EN adds out_parity (= ^out_data, registered).
//
//   Handshake rules (both sides): a transfer happens on a rising clk edge where
//   valid && ready. A source never drops valid or changes payload while it waits.
//   The sink may change ready at any time. in_ready only deasserts for a closing
//   beat while a previous word is still waiting in the output register.
module serial_to_parallel_stream #(
  parameter int IN_W      = 1,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [IN_W-1:0]                 in_data,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic                            out_valid,
  output logic [OUT_W-1:0]                out_data,
  output logic [$clog2(OUT_W/IN_W+1)-1:0] out_beats,
  input  logic                            out_ready
`ifdef S2P_PARITY_EN
  ,
  output logic                            out_parity
`endif
);

  localparam int BEATS = OUT_W / IN_W;
  localparam int CW    = $clog2(BEATS);
  localparam int BW    = $clog2(BEATS + 1);

  if (((OUT_W % IN_W) != 0) || (BEATS < 2)) begin : g_bad_cfg
    $error("serial_to_parallel_stream: OUT_W must be a multiple of IN_W with at least 2 beats");
  end

  // Output-side state. The accumulator side is tracked by r_cnt.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  out_state_t        r_out_state;
  logic [OUT_W-1:0]  r_acc;
  logic [CW-1:0]     r_cnt;
  logic [OUT_W-1:0]  r_out_data;
  logic [BW-1:0]     r_out_beats;
`ifdef S2P_PARITY_EN
  logic              r_out_parity;
`endif

  logic              w_last_slot;
  logic              w_closing;
  logic              w_accept;
  logic              w_drain;
  logic [CW-1:0]     w_slot;
  logic [OUT_W-1:0]  w_acc_next;

  // A beat closes the word when it fills the final slot or carries in_last.
  // Gating with in_valid keeps in_last from mattering while no beat is offered.
  assign w_last_slot = (r_cnt == CW'(BEATS - 1));
  assign w_closing   = in_valid && (w_last_slot || in_last);
  assign in_ready    = !w_closing || (r_out_state == OUT_EMPTY) || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_drain     = (r_out_state == OUT_FULL) && out_ready;

  // In MSB-first order, beat 0 goes to the top slot, so the slot index counts down.
  assign w_slot = (MSB_FIRST != 0) ? (CW'(BEATS - 1) - r_cnt) : r_cnt;

  // Merge the incoming beat into its slot of the accumulator.
  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < BEATS; k++) begin
      if (w_slot == CW'(k)) begin
        w_acc_next[k*IN_W +: IN_W] = in_data;
      end
    end
  end

  // Accumulator, beat counter and output register with its EMPTY/FULL state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_state  <= OUT_EMPTY;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_out_data   <= '0;
      r_out_beats  <= '0;
`ifdef S2P_PARITY_EN
      r_out_parity <= 1'b0;
`endif
    end else begin
      // Draining frees the register. A word that loads on the same edge overrides this below.
      if (w_drain) begin
        r_out_state <= OUT_EMPTY;
      end
      if (w_accept) begin
        if (w_closing) begin
          r_out_state  <= OUT_FULL;
          r_out_data   <= w_acc_next;
          r_out_beats  <= BW'(r_cnt) + BW'(1);
`ifdef S2P_PARITY_EN
          r_out_parity <= ^w_acc_next;
`endif
          r_acc        <= '0;
          r_cnt        <= '0;
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign out_valid  = (r_out_state == OUT_FULL);
  assign out_data   = r_out_data;
  assign out_beats  = r_out_beats;
`ifdef S2P_PARITY_EN
  assign out_parity = r_out_parity;
`endif

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// Bench for serial_to_parallel_stream.
//   dut0: IN_W=1, OUT_W=8, LSB first. dut1: same stream, MSB first.
//   dut2: IN_W=2, OUT_W=8, LSB first.
//   The model collects the accepted beats of each word. When a word closes, it
//   computes the expected packed value with plain shifts and queues it. A compare
//   process checks every word the DUT hands over, and checks that stalled outputs hold.
module tb_serial_to_parallel_stream;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       a_valid, a_data, a_last;
  logic       out_ready;
  logic       a0_ready, a1_ready;
  logic       o0_valid, o1_valid;
  logic [7:0] o0_data, o1_data;
  logic [3:0] o0_beats, o1_beats;

  logic       b_valid, b_last;
  logic [1:0] b_data;
  logic       b_ready;
  logic       o2_valid;
  logic [7:0] o2_data;
  logic [2:0] o2_beats;
`ifdef S2P_PARITY_EN
  logic       o0_par, o1_par, o2_par;
`endif

  serial_to_parallel_stream #(.IN_W(1), .OUT_W(8), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_last(a_last),
    .in_ready(a0_ready), .out_valid(o0_valid), .out_data(o0_data), .out_beats(o0_beats),
    .out_ready(out_ready)
`ifdef S2P_PARITY_EN
    , .out_parity(o0_par)
`endif
  );

  serial_to_parallel_stream #(.IN_W(1), .OUT_W(8), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_last(a_last),
    .in_ready(a1_ready), .out_valid(o1_valid), .out_data(o1_data), .out_beats(o1_beats),
    .out_ready(out_ready)
`ifdef S2P_PARITY_EN
    , .out_parity(o1_par)
`endif
  );

  serial_to_parallel_stream #(.IN_W(2), .OUT_W(8), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_last(b_last),
    .in_ready(b_ready), .out_valid(o2_valid), .out_data(o2_data), .out_beats(o2_beats),
    .out_ready(out_ready)
`ifdef S2P_PARITY_EN
    , .out_parity(o2_par)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic        a_bits[$];
  logic [1:0]  b_beats[$];
  logic [11:0] exp0_q[$];  // {beats, data}
  logic [11:0] exp1_q[$];
  logic [11:0] exp2_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // One accepted beat on the 1-bit stream, as seen by both LSB- and MSB-first packers.
  function automatic void model_a(input logic b, input logic last);
    logic [7:0] w0, w1;
    int n;
    a_bits.push_back(b);
    if (last || a_bits.size() == 8) begin
      n  = a_bits.size();
      w0 = 8'h00;
      w1 = 8'h00;
      for (int k = 0; k < n; k++) begin
        if (a_bits[k]) begin
          w0 = w0 + 8'(1 << k);
          w1 = w1 + 8'(1 << (7 - k));
        end
      end
      exp0_q.push_back({4'(n), w0});
      exp1_q.push_back({4'(n), w1});
      a_bits.delete();
    end
  endfunction

  // One accepted 2-bit beat.
  function automatic void model_b(input logic [1:0] v, input logic last);
    int acc;
    int n;
    b_beats.push_back(v);
    if (last || b_beats.size() == 4) begin
      n   = b_beats.size();
      acc = 0;
      for (int k = 0; k < n; k++) acc = acc + int'(b_beats[k]) * (4 ** k);
      exp2_q.push_back({4'(n), 8'(acc)});
      b_beats.delete();
    end
  endfunction

  task automatic check_out(input int idx, input logic [7:0] d, input logic [3:0] bts
`ifdef S2P_PARITY_EN
                           , input logic par
`endif
                           );
    logic [11:0] e;
    int sz;
    case (idx)
      0:       sz = exp0_q.size();
      1:       sz = exp1_q.size();
      default: sz = exp2_q.size();
    endcase
    chk($sformatf("dut%0d word expected", idx), 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      case (idx)
        0:       e = exp0_q.pop_front();
        1:       e = exp1_q.pop_front();
        default: e = exp2_q.pop_front();
      endcase
      chk($sformatf("dut%0d out_data", idx), 32'(d), 32'(e[7:0]));
      chk($sformatf("dut%0d out_beats", idx), 32'(bts), 32'(e[11:8]));
`ifdef S2P_PARITY_EN
      chk($sformatf("dut%0d out_parity", idx), 32'(par), 32'(^e[7:0]));
`endif
    end
  endtask

  // Compare process: values read here are the ones present just before the edge.
  logic [12:0] h0, h1, h2;
  logic        s0, s1, s2;
  always @(posedge clk) begin
    if (!rst) begin
      s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
    end else begin
      if (s0) chk("dut0 hold under stall", 32'({o0_valid, o0_beats, o0_data}), 32'(h0));
      if (s1) chk("dut1 hold under stall", 32'({o1_valid, o1_beats, o1_data}), 32'(h1));
      if (s2) chk("dut2 hold under stall", 32'({o2_valid, 1'b0, o2_beats, o2_data}), 32'(h2));
`ifdef S2P_PARITY_EN
      if (o0_valid && out_ready) check_out(0, o0_data, o0_beats, o0_par);
      if (o1_valid && out_ready) check_out(1, o1_data, o1_beats, o1_par);
      if (o2_valid && out_ready) check_out(2, o2_data, {1'b0, o2_beats}, o2_par);
`else
      if (o0_valid && out_ready) check_out(0, o0_data, o0_beats);
      if (o1_valid && out_ready) check_out(1, o1_data, o1_beats);
      if (o2_valid && out_ready) check_out(2, o2_data, {1'b0, o2_beats});
`endif
      s0 = o0_valid && !out_ready; h0 = {o0_valid, o0_beats, o0_data};
      s1 = o1_valid && !out_ready; h1 = {o1_valid, o1_beats, o1_data};
      s2 = o2_valid && !out_ready; h2 = {o2_valid, 1'b0, o2_beats, o2_data};
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge. Returns at the negedge that follows the accepting posedge.
  task automatic send_a(input logic b, input logic last);
    int t = 0;
    a_valid = 1'b1; a_data = b; a_last = last;
    #1;
    while (!(a0_ready && a1_ready) && t < 100) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 100) begin
      chk("stream a accept timeout", 32'(a0_ready && a1_ready), 32'd1);
    end else begin
      @(posedge clk);
      model_a(b, last);
    end
    @(negedge clk);
    a_valid = 1'b0;
    a_data  = 1'($urandom_range(0, 1));
    a_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_b(input logic [1:0] v, input logic last);
    int t = 0;
    b_valid = 1'b1; b_data = v; b_last = last;
    #1;
    while (!b_ready && t < 100) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 100) begin
      chk("stream b accept timeout", 32'(b_ready), 32'd1);
    end else begin
      @(posedge clk);
      model_b(v, last);
    end
    @(negedge clk);
    b_valid = 1'b0;
    b_data  = 2'($urandom_range(0, 3));
    b_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word_a(input logic [7:0] w, input int n);
    for (int k = 0; k < n; k++) send_a(w[k], 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0] vec;
  initial begin
    a_valid = 1'b0; a_data = 1'b0; a_last = 1'b0;
    b_valid = 1'b0; b_data = 2'b00; b_last = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset o0_valid", 32'(o0_valid), 32'd0);
    chk("reset o0_data", 32'(o0_data), 32'd0);
    chk("reset o0_beats", 32'(o0_beats), 32'd0);
    chk("reset o2_valid", 32'(o2_valid), 32'd0);
    chk("reset o2_beats", 32'(o2_beats), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("idle in_ready", 32'(a0_ready), 32'd1);
    @(negedge clk);

    // Bits 1,0,1,1,0,0,0,1 in send order.
    vec = 8'b1000_1101;
    for (int k = 0; k < 7; k++) send_a(vec[k], 1'b0);
    chk("no valid before final beat", 32'(o0_valid), 32'd0);
    send_a(vec[7], 1'b0);
    chk("full word latency valid", 32'(o0_valid), 32'd1);
    chk("lsb-first word", 32'(o0_data), 32'h8D);
    chk("lsb-first beats", 32'(o0_beats), 32'd8);
    chk("msb-first word", 32'(o1_data), 32'hB1);
    @(negedge clk);

    // Partial word: 1,1,0 then in_last.
    send_a(1'b1, 1'b0);
    send_a(1'b1, 1'b0);
    send_a(1'b0, 1'b1);
    chk("partial lsb-first word", 32'(o0_data), 32'h03);
    chk("partial beats", 32'(o0_beats), 32'd3);
    chk("partial msb-first word", 32'(o1_data), 32'hC0);
`ifdef S2P_PARITY_EN
    chk("parity of 03", 32'(o0_par), 32'd0);
`endif
    @(negedge clk);

    // 2-bit beats: 11, 01 with in_last.
    send_b(2'b11, 1'b0);
    send_b(2'b01, 1'b1);
    chk("2-bit partial word", 32'(o2_data), 32'h07);
    chk("2-bit partial beats", 32'(o2_beats), 32'd2);
`ifdef S2P_PARITY_EN
    chk("parity of 07", 32'(o2_par), 32'd1);
`endif
    // in_last on the final slot is an ordinary full word.
    send_b(2'b00, 1'b0);
    send_b(2'b10, 1'b0);
    send_b(2'b01, 1'b0);
    send_b(2'b11, 1'b1);
    chk("last on final slot word", 32'(o2_data), 32'hD8);
    chk("last on final slot beats", 32'(o2_beats), 32'd4);
    send_b(2'b10, 1'b1);
    chk("single-beat word", 32'(o2_data), 32'h02);
    @(negedge clk);

    // Backpressure: two full words with out_ready low.
    out_ready = 1'b0;
    send_word_a(8'hA5, 8);
    send_word_a(8'h3C, 7);
    fork
      send_a(1'b0, 1'b0);  // bit 7 of 3C closes the second word
      begin
        repeat (3) begin
          @(negedge clk); #2;
          chk("closing beat stalls", 32'(a0_ready), 32'd0);
          chk("stalled word held", 32'(o0_data), 32'hA5);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    chk("no bubble after drain+load", 32'(o0_valid), 32'd1);
    chk("second word loaded", 32'(o0_data), 32'h3C);
    repeat (3) @(negedge clk);

    // Reset mid-word discards the partial word.
    send_a(1'b1, 1'b0);
    send_a(1'b1, 1'b0);
    send_a(1'b1, 1'b0);
    rst = 1'b0;
    a_bits.delete();
    #1;
    chk("mid-word reset valid", 32'(o0_valid), 32'd0);
    chk("mid-word reset data", 32'(o0_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_word_a(8'h5A, 8);
    chk("post-reset word", 32'(o0_data), 32'h5A);
    chk("post-reset beats", 32'(o0_beats), 32'd8);

    repeat (4) @(negedge clk);
    chk("dut0 queue drained", 32'(exp0_q.size()), 32'd0);
    chk("dut1 queue drained", 32'(exp1_q.size()), 32'd0);
    chk("dut2 queue drained", 32'(exp2_q.size()), 32'd0);
    chk("no leftover output", 32'(o0_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
